// File: rtl/rpn_operand_stack.sv
// rpn_operand_stack: fixed-depth RPN operand LIFO with single-cycle ops and a shift-add MUL sequencer.
// Exposes top/next and a one-cycle result strobe for downstream load enables.
module rpn_operand_stack #(
  parameter int K     = 16,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  input  logic [2:0]    cmd,
  input  logic [K-1:0]  din,
  output logic          cmd_ready,
  output logic [K-1:0]  top,
  output logic [K-1:0]  next,
  output logic [CW-1:0] count,
  output logic          result_strobe,
  output logic          err_overflow,
  output logic          err_underflow
);
  localparam int IW = $clog2(K + 1);
  localparam logic [2:0] PUSH = 3'd1, POP = 3'd2, ADD = 3'd3, SUB = 3'd4,
                         MUL = 3'd5, SWAP = 3'd6, CLEAR = 3'd7;
  typedef enum logic {IDLE, MUL_RUN} state_t;
  state_t state, state_d;
  logic [DEPTH-1:0][K-1:0] ent, ent_d, shifted;
  logic [CW-1:0] cnt_d;
  logic stb_d, ovf_d, unf_d;
  logic [K-1:0] mcand, mplier, acc, acc_nxt;
  logic [IW-1:0] iter;
  logic accept, two, full, empty, mul_go, mul_done;
  assign accept   = cmd_valid && cmd_ready;
  assign two      = count >= CW'(2);
  assign full     = count == CW'(DEPTH);
  assign empty    = count == '0;
  assign mul_go   = accept && cmd == MUL && two;
  assign mul_done = state == MUL_RUN && iter == IW'(K - 1);
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  // Pop view: every entry moves one slot toward the top, bottom fills with 0.
  assign shifted  = ent >> K;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_d;
  end
  always_comb state_d = state == IDLE ? (mul_go ? MUL_RUN : IDLE) : (mul_done ? IDLE : MUL_RUN);
  always_comb begin
    cmd_ready = state == IDLE;
    top       = empty ? '0 : ent[0];
    next      = two ? ent[1] : '0;
  end
  always_comb begin
    ent_d = ent;
    cnt_d = count;
    stb_d = 1'b0;
    ovf_d = err_overflow;
    unf_d = err_underflow;
    if (mul_done) begin
      ent_d    = shifted;
      ent_d[0] = acc_nxt;
      cnt_d    = count - CW'(1);
      stb_d    = 1'b1;
    end else if (accept) begin
      case (cmd)
        PUSH:
          if (full) ovf_d = 1'b1;
          else begin
            ent_d = {ent[DEPTH-2:0], din};
            cnt_d = count + CW'(1);
            stb_d = 1'b1;
          end
        POP:
          if (empty) unf_d = 1'b1;
          else begin
            ent_d = shifted;
            cnt_d = count - CW'(1);
            stb_d = 1'b1;
          end
        ADD, SUB:
          if (!two) unf_d = 1'b1;
          else begin
            ent_d    = shifted;
            ent_d[0] = cmd == ADD ? ent[1] + ent[0] : ent[1] - ent[0];
            cnt_d    = count - CW'(1);
            stb_d    = 1'b1;
          end
        SWAP:
          if (!two) unf_d = 1'b1;
          else begin
            ent_d[0] = ent[1];
            ent_d[1] = ent[0];
            stb_d    = 1'b1;
          end
        MUL:     unf_d = err_underflow || !two;
        CLEAR: begin
          ent_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent           <= '0;
      count         <= '0;
      result_strobe <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      ent           <= ent_d;
      count         <= cnt_d;
      result_strobe <= stb_d;
      err_overflow  <= ovf_d;
      err_underflow <= unf_d;
    end
  end
  // Shift-add multiplier: one multiplier bit per cycle, product truncated to K bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      iter   <= '0;
    end else if (mul_go) begin
      mcand  <= ent[1];
      mplier <= ent[0];
      acc    <= '0;
      iter   <= '0;
    end else if (state == MUL_RUN) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      iter   <= iter + IW'(1);
    end
  end
endmodule

// File: doc/rpn_operand_stack.md
Name: rpn_operand_stack

Overview:
- Operand stack and sequencer for the RPN calculator; sits directly upstream of the load-enabled result/display registers.
- Accepts push/pop/arithmetic commands and maintains a fixed-depth LIFO.
- Presents the top two entries (top, next) and a one-cycle result strobe that drives the downstream register load enables.
- Single-cycle commands except MUL, which runs a sequential shift-add over K cycles.

Parameters:
K, 16, data word width in bits
DEPTH, 4, number of stack entries (>=2)
CW, 3, width of depth counter; must hold 0..DEPTH (clog2(DEPTH+1))

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present this cycle
cmd  input  3  opcode: 0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 MUL, 6 SWAP, 7 CLEAR
din  input  K  operand for PUSH
cmd_ready  output  1  high when a command can be accepted (IDLE state)
top  output  K  stack entry 0; 0 when count=0
next  output  K  stack entry 1; 0 when count<2
count  output  CW  number of valid entries
result_strobe  output  1  one-cycle pulse when top was updated by ADD/SUB/MUL/PUSH/POP/SWAP; drives downstream load enable
err_overflow  output  1  sticky: PUSH attempted with count=DEPTH
err_underflow  output  1  sticky: POP with count=0, or binary op/SWAP with count<2

Behaviour:
- Reset (async, any state, including mid-MUL): all entries 0, count=0, state IDLE, cmd_ready=1, result_strobe=0, both error flags 0, MUL datapath cleared.
- States: IDLE, MUL_RUN. cmd_ready = (state==IDLE). Command accepted on rising edge with cmd_valid && cmd_ready; cmd/din ignored when cmd_ready=0.
- All single-cycle commands take effect on the accepting edge; outputs reflect the new state in the following cycle; result_strobe high that same following cycle only.
- PUSH: entries shift down, entry0=din, count+1. If count=DEPTH: no change, err_overflow<=1, no strobe.
- POP: entries shift up, bottom entry<=0, count-1. If count=0: no change, err_underflow<=1, no strobe.
- ADD: entry0<=(entry1+entry0) mod 2^K; entries below shift up; count-1.
- SUB: entry0<=(entry1-entry0) mod 2^K (RPN order: next minus top); shift/count as ADD.
- SWAP: exchange entry0/entry1; count unchanged.
- ADD/SUB/SWAP/MUL with count<2: no change, err_underflow<=1, no strobe, MUL does not enter MUL_RUN.
- MUL (unsigned, low K bits of product): on accept latch multiplicand=entry1, multiplier=entry0, acc=0, iteration counter=0, go to MUL_RUN. Each MUL_RUN cycle: if multiplier LSB then acc+=multiplicand; multiplicand<<=1; multiplier>>=1; counter+1. On the edge completing iteration K: stack pop-and-replace as ADD with acc result, state IDLE, result_strobe next cycle. Accept-to-ready latency exactly K+1 edges (ready low K cycles).
- CLEAR: all entries 0, count=0, both error flags 0, no strobe. Only CLEAR or reset clears error flags.
- NOP: accepted, no effect.
- Error flags do not block subsequent commands.
- count never exceeds DEPTH nor goes negative.

Test Plan:
- Reset, then PUSH 5, PUSH 7, ADD -> top=12, count=1, result_strobe pulsed once per command (3 pulses).
- PUSH 3, PUSH 10, SUB -> top=0xFFF9 (3-10 mod 2^16), count=1; PUSH 0xFFFF, PUSH 2, ADD -> top=0x0001.
- PUSH 300, PUSH 300, MUL -> cmd_ready low exactly 16 cycles, then top=0x5F90 (90000 mod 65536), count=1; cmd_valid pulses during busy ignored.
- PUSH 1..4 (count=4), PUSH 9 -> err_overflow=1, top=4, count=4; CLEAR -> count=0, flags 0; POP -> err_underflow=1, count=0.
- PUSH 1, ADD -> err_underflow=1, top=1, count=1, no strobe; PUSH 2, SWAP -> top=1, next=2.
- PUSH 6, PUSH 7, MUL, assert reset 5 cycles into MUL_RUN -> immediately count=0, top=0, cmd_ready=1, flags 0; next PUSH 4 -> top=4.
